vend_coin_conditioner: RTL and testbench
========================================

Name: vend_coin_conditioner

Overview:
- Upstream stage of the vending Moore controller. Turns two raw, asynchronous, bouncy coin-sensor lines into clean single-cycle coin codes on D_in[1:0].
- Coins that arrive while the controller is dispensing are buffered in per-channel pending counters and presented afterwards, so no coin is silently dropped.
- Channel half = 0.5-yuan coin, drives D_in[0]. Channel one = 1-yuan coin, drives D_in[1].

Parameters:
- SYNC_STAGES, 2, synchronizer flop depth per raw input (minimum 2).
- DEBOUNCE_CYCLES, 8, consecutive cycles a synced level must differ from the accepted level before it is accepted.
- CNT_W, 4, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- PEND_MAX, 3, saturation value of each pending counter; counter width 2 bits.

Ports:
- Clk, input, 1, system clock; all state on rising edge.
- Reset, input, 1, asynchronous active-high reset.
- coin_half_raw, input, 1, raw 0.5-yuan sensor, asynchronous, may bounce.
- coin_one_raw, input, 1, raw 1-yuan sensor, asynchronous, may bounce.
- hold, input, 1, controller busy; driven by the controller's D_out_moore (high in the dispense state).
- D_in, output, 2, coin code to the controller: 01 = half, 10 = one, 00 = none; never 11.
- pend_half, output, 2, pending 0.5-yuan count (debug).
- pend_one, output, 2, pending 1-yuan count (debug).
- overflow, output, 1, sticky: a coin event was lost to saturation.

Behaviour:
- Interface: one clock Clk; Reset asynchronous active-high. All registers clear on Reset: sync chains 0, stable levels 0, debounce counters 0, pend_half 0, pend_one 0, overflow 0. D_in is therefore 00 during reset.
- Sync: each raw input passes through SYNC_STAGES flops; only the last stage is used.
- Debounce, per channel, with registers stable and cnt:
  - synced == stable: cnt <= 0.
  - synced != stable and cnt == DEBOUNCE_CYCLES-1: stable <= synced, cnt <= 0.
  - otherwise: cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES never changes stable.
- Event: a rising edge of stable (prev 0, now 1) produces a one-cycle internal coin event. Falling edges produce nothing. A held-high sensor yields exactly one event.
- Emission, combinational from registers plus hold:
  - hold = 1: D_in = 00.
  - else pend_one != 0: D_in = 10.
  - else pend_half != 0: D_in = 01.
  - else D_in = 00.
  - At most one coin per cycle; 1-yuan has priority.
- Pending update each edge, per channel: pend <= pend + ev - em, where em = this channel emitted this cycle.
  - Simultaneous ev and em: count unchanged.
  - ev with pend == PEND_MAX and no em: count stays PEND_MAX, overflow <= 1.
- Latency: clean sensor rise to D_in asserted = SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles when idle and hold = 0.
- hold = 1 for any number of cycles: events keep accumulating; emission resumes the first cycle hold = 0.
- overflow is cleared only by Reset.
- Reset mid-debounce or with pending coins discards everything; a sensor still high after reset produces one event after the debounce delay.
- No combinational loop: D_in depends on registers and hold only; hold must not depend on D_in in the same cycle.

Decomposition:
- Shared package vend_pkg: coin code constants COIN_NONE = 2'b00, COIN_HALF = 2'b01, COIN_ONE = 2'b10.
- One sub-module coin_debounce (sync chain + debounce + rising-edge event), instantiated twice with parameters SYNC_STAGES, DEBOUNCE_CYCLES, CNT_W.
- Pending counters, emission arbiter and overflow flag live in the top module.

Test Plan (bench uses DEBOUNCE_CYCLES=4, SYNC_STAGES=2, hold=0 unless stated):
- Clean coin_one_raw high for 10 cycles -> D_in = 10 for exactly 1 cycle, 7 cycles after the rise; pend_one returns to 0.
- coin_half_raw toggling 1/0 every cycle for 6 cycles, then steady 0 -> D_in stays 00, overflow = 0.
- Both sensors rise in the same cycle -> D_in = 10 on cycle n, then 01 on cycle n+1; never 11.
- hold = 1 while 2 half coins and 1 one coin are debounced -> D_in = 00, pend_half = 2, pend_one = 1; after hold drops, D_in sequence is 10, 01, 01, then 00.
- hold = 1 and 4 one-coins inserted -> pend_one saturates at 3 and overflow = 1; release hold -> exactly 3 cycles of D_in = 10.
- Assert Reset with pend_half = 2 mid-debounce -> all outputs 0 immediately (asynchronous); after release with sensors low, D_in stays 00.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared coin codes and pending-counter helpers for the vending front end.
package vend_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_HALF = 2'b01;
  localparam logic [1:0] COIN_ONE  = 2'b10;

  localparam int PEND_W = 2;
  typedef logic [PEND_W-1:0] pend_t;

  // Saturating pend + ev - em; an event that lands on a full counter is lost.
  function automatic pend_t pend_next(input pend_t cur, input logic ev,
                                      input logic em, input pend_t max);
    pend_t nxt;
    nxt = cur;
    if (ev && !em) begin
      if (cur != max) nxt = cur + pend_t'(1);
    end else if (!ev && em) begin
      nxt = cur - pend_t'(1);
    end
    return nxt;
  endfunction

  function automatic logic pend_lost(input pend_t cur, input logic ev,
                                     input logic em, input pend_t max);
    return ev && !em && (cur == max);
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// One sensor channel: synchronizer chain, level debouncer and a single-cycle
// event on each accepted rising edge of the debounced level.
module coin_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CNT_W           = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic event_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   stable_q, stable_d;
  logic                   prev_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (synced != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = synced;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], raw_i};
      stable_q <= stable_d;
      prev_q   <= stable_q;
      cnt_q    <= cnt_d;
    end
  end

  // Rising edge only: a sensor held high gives exactly one event.
  assign event_o = stable_q & ~prev_q;

endmodule

// File: rtl/vend_coin_conditioner.sv
// Conditions two raw coin sensors into one-coin-per-cycle codes for the
// vending controller, buffering coins that arrive while it is dispensing.
module vend_coin_conditioner
  import vend_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CNT_W           = 4,
  parameter int PEND_MAX        = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       coin_half_raw,
  input  logic       coin_one_raw,
  input  logic       hold,
  output logic [1:0] D_in,
  output logic [1:0] pend_half,
  output logic [1:0] pend_one,
  output logic       overflow
);

  localparam pend_t PEND_CAP = pend_t'(PEND_MAX);

  logic  ev_half, ev_one;
  logic  em_half, em_one;
  pend_t pend_half_q, pend_half_d;
  pend_t pend_one_q, pend_one_d;
  logic  overflow_q, overflow_d;

  coin_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_half (
    .clk_i  (Clk),
    .rst_i  (Reset),
    .raw_i  (coin_half_raw),
    .event_o(ev_half)
  );

  coin_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_one (
    .clk_i  (Clk),
    .rst_i  (Reset),
    .raw_i  (coin_one_raw),
    .event_o(ev_one)
  );

  // Emission uses registers and hold only, so hold may come from a Moore output.
  always_comb begin
    em_one  = 1'b0;
    em_half = 1'b0;
    D_in    = COIN_NONE;
    if (!hold) begin
      if (pend_one_q != '0) begin
        em_one = 1'b1;
        D_in   = COIN_ONE;
      end else if (pend_half_q != '0) begin
        em_half = 1'b1;
        D_in    = COIN_HALF;
      end
    end
  end

  always_comb begin
    pend_half_d = pend_next(pend_half_q, ev_half, em_half, PEND_CAP);
    pend_one_d  = pend_next(pend_one_q, ev_one, em_one, PEND_CAP);
    overflow_d  = overflow_q
                | pend_lost(pend_half_q, ev_half, em_half, PEND_CAP)
                | pend_lost(pend_one_q, ev_one, em_one, PEND_CAP);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pend_half_q <= '0;
      pend_one_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      pend_half_q <= pend_half_d;
      pend_one_q  <= pend_one_d;
      overflow_q  <= overflow_d;
    end
  end

  assign pend_half = pend_half_q;
  assign pend_one  = pend_one_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_vend_coin_conditioner.sv
// Scoreboard bench for vend_coin_conditioner: expected coins (code, cycle) are
// queued as sensors are driven and matched against D_in as it appears.
module tb_vend_coin_conditioner;
  import vend_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       coin_half_raw;
  logic       coin_one_raw;
  logic       hold;
  logic [1:0] D_in;
  logic [1:0] pend_half;
  logic [1:0] pend_one;
  logic       overflow;

  vend_coin_conditioner #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3),
    .PEND_MAX       (3)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .coin_half_raw(coin_half_raw),
    .coin_one_raw (coin_one_raw),
    .hold         (hold),
    .D_in         (D_in),
    .pend_half    (pend_half),
    .pend_one     (pend_one),
    .overflow     (overflow)
  );

  always #5 Clk = ~Clk;

  localparam int LAT = 2 + 4 + 1;

  typedef struct {
    logic [1:0] code;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fails = 0;
  int   r;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic push(input logic [1:0] code, input int at);
    exp_t e;
    e.code = code;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic pulse_half(input int hi, input int lo);
    coin_half_raw = 1'b1;
    tick(hi);
    coin_half_raw = 1'b0;
    tick(lo);
  endtask

  // Every non-zero D_in must match the head of the scoreboard in code and cycle.
  always @(negedge Clk) begin
    if (!Reset && D_in != COIN_NONE) begin
      check("d_in_not_11", 32'(D_in == 2'b11), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_coin", 32'(D_in), 32'(COIN_NONE));
      end else begin
        mon_e = exp_q.pop_front();
        check("coin_code", 32'(D_in), 32'(mon_e.code));
        check("coin_cycle", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    Reset = 1'b1;
    hold = 1'b0;
    coin_half_raw = 1'b0;
    coin_one_raw = 1'b0;
    tick(3);
    check("rst_d_in", 32'(D_in), 0);
    check("rst_pend_half", 32'(pend_half), 0);
    check("rst_pend_one", 32'(pend_one), 0);
    check("rst_overflow", 32'(overflow), 0);
    Reset = 1'b0;
    tick(5);

    // Clean 1-yuan coin
    push(COIN_ONE, cyc + LAT);
    coin_one_raw = 1'b1;
    tick(10);
    coin_one_raw = 1'b0;
    tick(20);
    check("t1_pend_one", 32'(pend_one), 0);
    check("t1_queue_empty", exp_q.size(), 0);

    // Bouncing half sensor never reaches the debounce threshold
    for (int i = 0; i < 6; i++) begin
      coin_half_raw = (i % 2 == 0);
      tick(1);
    end
    coin_half_raw = 1'b0;
    tick(20);
    check("t2_overflow", 32'(overflow), 0);
    check("t2_pend_half", 32'(pend_half), 0);
    check("t2_queue_empty", exp_q.size(), 0);

    // Simultaneous coins: one first, half next cycle
    push(COIN_ONE, cyc + LAT);
    push(COIN_HALF, cyc + LAT + 1);
    coin_half_raw = 1'b1;
    coin_one_raw = 1'b1;
    tick(10);
    coin_half_raw = 1'b0;
    coin_one_raw = 1'b0;
    tick(20);
    check("t3_queue_empty", exp_q.size(), 0);

    // Coins buffered under hold, drained after release
    hold = 1'b1;
    tick(1);
    coin_one_raw = 1'b1;
    pulse_half(8, 8);
    coin_one_raw = 1'b0;
    pulse_half(8, 10);
    check("t4_hold_d_in", 32'(D_in), 0);
    check("t4_pend_half", 32'(pend_half), 2);
    check("t4_pend_one", 32'(pend_one), 1);
    r = cyc;
    push(COIN_ONE, r);
    push(COIN_HALF, r + 1);
    push(COIN_HALF, r + 2);
    hold = 1'b0;
    tick(10);
    check("t4_queue_empty", exp_q.size(), 0);
    check("t4_pend_half_drained", 32'(pend_half), 0);

    // Saturation: four one-coins under hold
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      coin_one_raw = 1'b1;
      tick(8);
      coin_one_raw = 1'b0;
      tick(8);
    end
    tick(4);
    check("t5_pend_one_sat", 32'(pend_one), 3);
    check("t5_overflow_set", 32'(overflow), 1);
    r = cyc;
    for (int i = 0; i < 3; i++) push(COIN_ONE, r + i);
    hold = 1'b0;
    tick(10);
    check("t5_queue_empty", exp_q.size(), 0);
    check("t5_pend_one_drained", 32'(pend_one), 0);
    check("t5_overflow_sticky", 32'(overflow), 1);

    // Asynchronous reset with pending coins and a debounce in flight
    hold = 1'b1;
    pulse_half(8, 8);
    pulse_half(8, 10);
    check("t6_pend_half_pre", 32'(pend_half), 2);
    coin_half_raw = 1'b1;
    tick(3);
    #2 Reset = 1'b1;
    #1;
    check("t6_async_d_in", 32'(D_in), 0);
    check("t6_async_pend_half", 32'(pend_half), 0);
    check("t6_async_pend_one", 32'(pend_one), 0);
    check("t6_async_overflow", 32'(overflow), 0);
    hold = 1'b0;
    coin_half_raw = 1'b0;
    tick(2);
    Reset = 1'b0;
    tick(20);
    check("t6_queue_empty", exp_q.size(), 0);
    check("t6_idle_d_in", 32'(D_in), 0);

    // Sensor held high across reset yields one coin after the debounce delay
    Reset = 1'b1;
    coin_one_raw = 1'b1;
    tick(2);
    Reset = 1'b0;
    push(COIN_ONE, cyc + LAT);
    tick(15);
    coin_one_raw = 1'b0;
    tick(20);
    check("t7_queue_empty", exp_q.size(), 0);
    check("t7_overflow", 32'(overflow), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
